accum_ofs_expander: RTL and testbench



---
 rtl/accum_ofs_expander_pkg.sv | 15 +
 rtl/accum_ofs_expander_step.sv | 39 +++
 rtl/accum_ofs_expander.sv | 183 ++++++++++++++++++
 tb/tb_accum_ofs_expander.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_ofs_expander_pkg.sv
// TauCfg: shared configuration for the tau datapath.
// Supplies the work word width, the number of offset dimensions and the
// state type of the accumulation-offset expander.
package TauCfg;

    localparam int WORK_BW = 16;
    localparam int DIM     = 2;

    // Expander states: waiting for a token, or walking a tile.
    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_BUSY = 1'b1
    } AccumExpState;

endpackage

// File: rtl/accum_ofs_expander_step.sv
// NdOfsStep: one step of an N-dimensional offset counter.
// Given the current offset and the inclusive [aofs, alast] box, produces
// the next offset (innermost dimension DIM-1 counts fastest) and flags
// whether the current offset is the final one of the box. A dimension
// with aofs > alast counts as a single element because the compare is >=.
// Purely combinational so it can be reused by other address paths.
module NdOfsStep #(
    parameter int WBW = TauCfg::WORK_BW,
    parameter int DIM = TauCfg::DIM
) (
    input  logic [WBW-1:0] cur   [DIM],
    input  logic [WBW-1:0] aofs  [DIM],
    input  logic [WBW-1:0] alast [DIM],
    output logic [WBW-1:0] nxt   [DIM],
    output logic           islast
);

    logic carry;

    // Ripple the carry from the innermost dimension outwards; a dimension
    // at (or past) its last value reloads its start and passes the carry on.
    always_comb begin
        carry  = 1'b1;
        islast = 1'b1;
        for (int i = DIM - 1; i >= 0; i--) begin
            nxt[i] = cur[i];
            if (cur[i] < alast[i]) begin
                islast = 1'b0;
                if (carry) begin
                    nxt[i] = cur[i] + WBW'(1);
                    carry  = 1'b0;
                end
            end else if (carry) begin
                nxt[i] = aofs[i];
            end
        end
    end

endmodule

// File: rtl/accum_ofs_expander.sv
// accum_ofs_expander: receives one {bofs, aofs, alast} token per
// accumulation tile and emits every offset from aofs to alast inclusive,
// one per ofs handshake, with a last flag and a tile-done pulse.
//
// Build option: define ACCUM_EXPAND_PREFETCH_EN to add a one-entry token
// holding register so the next tile starts with no bubble cycle.
//
// Handshake (both ports): rdy is the valid side, ack the accept side; a
// transfer happens in every cycle where both are high. abofs_ack is
// combinational from abofs_rdy; ofs_ack may only be raised while ofs_rdy.
// All outputs read 0 while i_rst is high.
module accum_ofs_expander
    import TauCfg::*;
#(
    parameter int WBW = TauCfg::WORK_BW,
    parameter int DIM = TauCfg::DIM
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               abofs_rdy,
    output logic               abofs_ack,
    input  logic [WBW-1:0]     i_bofs  [DIM],
    input  logic [WBW-1:0]     i_aofs  [DIM],
    input  logic [WBW-1:0]     i_alast [DIM],
    output logic               ofs_rdy,
    input  logic               ofs_ack,
    output logic [WBW-1:0]     o_bofs  [DIM],
    output logic [WBW-1:0]     o_aofs  [DIM],
    output logic               o_islast,
    output logic               tokdone_dval,
    output AccumExpState       dbg_state
);

    AccumExpState   state;
    logic [WBW-1:0] cur_q   [DIM];
    logic [WBW-1:0] aofs_q  [DIM];
    logic [WBW-1:0] alast_q [DIM];
    logic [WBW-1:0] bofs_q  [DIM];
    logic           islast_q;

`ifdef ACCUM_EXPAND_PREFETCH_EN
    logic           hold_full;
    logic [WBW-1:0] hold_bofs  [DIM];
    logic [WBW-1:0] hold_aofs  [DIM];
    logic [WBW-1:0] hold_alast [DIM];
`endif

    logic [WBW-1:0] step_nxt [DIM];
    logic           step_islast;

    logic           busy;
    logic           advance;
    logic           tile_end;
    logic           load_in;
    logic           load_hold;
    logic           hold_store;

    AccumExpState   nxt_state;
    logic [WBW-1:0] nxt_cur   [DIM];
    logic [WBW-1:0] nxt_aofs  [DIM];
    logic [WBW-1:0] nxt_alast [DIM];
    logic [WBW-1:0] nxt_bofs  [DIM];
    logic           nxt_islast;

    NdOfsStep #(
        .WBW (WBW),
        .DIM (DIM)
    ) u_step (
        .cur    (cur_q),
        .aofs   (aofs_q),
        .alast  (alast_q),
        .nxt    (step_nxt),
        .islast (step_islast)
    );

    // Handshake decode: token acceptance, offset step and tile completion.
    always_comb begin
        busy    = (state == ACC_BUSY);
`ifdef ACCUM_EXPAND_PREFETCH_EN
        abofs_ack = abofs_rdy && !hold_full && !i_rst;
`else
        abofs_ack = abofs_rdy && !busy && !i_rst;
`endif
        ofs_rdy  = busy && !i_rst;
        advance  = ofs_rdy && ofs_ack && !step_islast;
        tile_end = ofs_rdy && ofs_ack && step_islast;
`ifdef ACCUM_EXPAND_PREFETCH_EN
        // An accepted token goes straight into the counter when the block is
        // idle or the current tile ends this cycle; otherwise it is parked.
        load_hold  = tile_end && hold_full;
        load_in    = abofs_ack && (!busy || tile_end);
        hold_store = abofs_ack && busy && !tile_end;
`else
        load_hold  = 1'b0;
        load_in    = abofs_ack;
        hold_store = 1'b0;
`endif
    end

    // Next counter, latch and state values, plus the last flag of the new offset.
    always_comb begin
        nxt_state = state;
        nxt_cur   = cur_q;
        nxt_aofs  = aofs_q;
        nxt_alast = alast_q;
        nxt_bofs  = bofs_q;
        if (advance) begin
            nxt_cur = step_nxt;
        end
        if (tile_end) begin
            nxt_state = ACC_IDLE;
        end
`ifdef ACCUM_EXPAND_PREFETCH_EN
        if (load_hold) begin
            nxt_cur   = hold_aofs;
            nxt_aofs  = hold_aofs;
            nxt_alast = hold_alast;
            nxt_bofs  = hold_bofs;
            nxt_state = ACC_BUSY;
        end
`endif
        if (load_in) begin
            nxt_cur   = i_aofs;
            nxt_aofs  = i_aofs;
            nxt_alast = i_alast;
            nxt_bofs  = i_bofs;
            nxt_state = ACC_BUSY;
        end
        nxt_islast = 1'b1;
        for (int i = 0; i < DIM; i++) begin
            if (nxt_cur[i] < nxt_alast[i]) begin
                nxt_islast = 1'b0;
            end
        end
    end

    // IDLE/BUSY state machine with its registered offset, latches and last flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ACC_IDLE;
            cur_q    <= '{default: '0};
            aofs_q   <= '{default: '0};
            alast_q  <= '{default: '0};
            bofs_q   <= '{default: '0};
            islast_q <= 1'b0;
`ifdef ACCUM_EXPAND_PREFETCH_EN
            hold_full  <= 1'b0;
            hold_bofs  <= '{default: '0};
            hold_aofs  <= '{default: '0};
            hold_alast <= '{default: '0};
`endif
        end else begin
            state    <= nxt_state;
            cur_q    <= nxt_cur;
            aofs_q   <= nxt_aofs;
            alast_q  <= nxt_alast;
            bofs_q   <= nxt_bofs;
            islast_q <= nxt_islast;
`ifdef ACCUM_EXPAND_PREFETCH_EN
            if (hold_store) begin
                hold_full  <= 1'b1;
                hold_bofs  <= i_bofs;
                hold_aofs  <= i_aofs;
                hold_alast <= i_alast;
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
`endif
        end
    end

    // Output drive; forced to zero during the reset cycle itself.
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            o_bofs[i] = i_rst ? '0 : bofs_q[i];
            o_aofs[i] = i_rst ? '0 : cur_q[i];
        end
        o_islast     = islast_q && !i_rst;
        tokdone_dval = ofs_rdy && ofs_ack && islast_q;
        dbg_state    = i_rst ? ACC_IDLE : state;
    end

endmodule

// File: tb/tb_accum_ofs_expander.sv
// tb_accum_ofs_expander: bench for the accumulation-offset expander.
// Expected offsets come from a nested-loop enumeration of the tile box.
module tb_accum_ofs_expander;
    import TauCfg::*;

    localparam int W = 8;
`ifdef ACCUM_EXPAND_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Two-dimensional instance
    logic         abofs_rdy = 1'b0;
    logic         abofs_ack;
    logic [W-1:0] bofs  [2] = '{default: '0};
    logic [W-1:0] aofs  [2] = '{default: '0};
    logic [W-1:0] alast [2] = '{default: '0};
    logic         ofs_rdy;
    logic         ofs_ack = 1'b0;
    logic [W-1:0] o_bofs [2];
    logic [W-1:0] o_aofs [2];
    logic         o_islast;
    logic         tokdone;
    AccumExpState dbg_state;

    // One-dimensional instance for the large-value case
    logic         d1_rdy = 1'b0;
    logic         d1_abofs_ack;
    logic [W-1:0] d1_bofs  [1] = '{default: '0};
    logic [W-1:0] d1_aofs  [1] = '{default: '0};
    logic [W-1:0] d1_alast [1] = '{default: '0};
    logic         d1_ofs_rdy;
    logic         d1_ofs_ack = 1'b0;
    logic [W-1:0] d1_o_bofs [1];
    logic [W-1:0] d1_o_aofs [1];
    logic         d1_o_islast;
    logic         d1_tokdone;
    AccumExpState d1_dbg_state;

    int errors = 0;
    int checks = 0;

    logic [2*W-1:0] exp_q[$];
    logic           last_q[$];

    accum_ofs_expander #(.WBW(W), .DIM(2)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .abofs_rdy    (abofs_rdy),
        .abofs_ack    (abofs_ack),
        .i_bofs       (bofs),
        .i_aofs       (aofs),
        .i_alast      (alast),
        .ofs_rdy      (ofs_rdy),
        .ofs_ack      (ofs_ack),
        .o_bofs       (o_bofs),
        .o_aofs       (o_aofs),
        .o_islast     (o_islast),
        .tokdone_dval (tokdone),
        .dbg_state    (dbg_state)
    );

    accum_ofs_expander #(.WBW(W), .DIM(1)) u_dut1 (
        .i_clk        (clk),
        .i_rst        (rst),
        .abofs_rdy    (d1_rdy),
        .abofs_ack    (d1_abofs_ack),
        .i_bofs       (d1_bofs),
        .i_aofs       (d1_aofs),
        .i_alast      (d1_alast),
        .ofs_rdy      (d1_ofs_rdy),
        .ofs_ack      (d1_ofs_ack),
        .o_bofs       (d1_o_bofs),
        .o_aofs       (d1_o_aofs),
        .o_islast     (d1_o_islast),
        .tokdone_dval (d1_tokdone),
        .dbg_state    (d1_dbg_state)
    );

    // Reference model: enumerate the box row-major, innermost index fastest.
    task automatic build_model(input int a0, input int a1, input int l0, input int l1);
        int h0;
        int h1;
        exp_q.delete();
        last_q.delete();
        h0 = (l0 > a0) ? l0 : a0;
        h1 = (l1 > a1) ? l1 : a1;
        for (int x = a0; x <= h0; x++) begin
            for (int y = a1; y <= h1; y++) begin
                exp_q.push_back({W'(x), W'(y)});
                last_q.push_back((x == h0) && (y == h1));
            end
        end
    endtask

    // Drive one token and consume the whole tile; mode 0=ack always, 1=toggle, 2=random.
    task automatic run_tile(input logic [W-1:0] b0, input logic [W-1:0] b1,
                            input logic [W-1:0] a0, input logic [W-1:0] a1,
                            input logic [W-1:0] l0, input logic [W-1:0] l1,
                            input int mode, input string name);
        int  cyc;
        int  n_exp;
        int  n_acked;
        bit  tog;
        bit  ack;
        build_model(a0, a1, l0, l1);
        n_exp = exp_q.size();
        @(posedge clk); #1;
        abofs_rdy = 1'b1;
        bofs  = '{b0, b1};
        aofs  = '{a0, a1};
        alast = '{l0, l1};
        #1;
        cyc = 0;
        while (abofs_ack !== 1'b1 && cyc < 20) begin
            @(posedge clk); #2;
            cyc++;
        end
        checks++;
        if (abofs_ack !== 1'b1) begin
            errors++;
            $display("FAIL %s token_ack: got %b required 1", name, abofs_ack);
            abofs_rdy = 1'b0;
            return;
        end
        @(posedge clk); #1;
        abofs_rdy = 1'b0;
        tog = 1'b1;
        n_acked = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            case (mode)
                0:       ack = 1'b1;
                1:       begin ack = tog; tog = !tog; end
                default: ack = 1'($urandom_range(0, 1));
            endcase
            ofs_ack = ack;
            #1;
            checks++;
            if (ofs_rdy !== 1'b1) begin
                errors++;
                $display("FAIL %s ofs_rdy: got %b required 1", name, ofs_rdy);
            end
            checks++;
            if ({o_aofs[0], o_aofs[1]} !== exp_q[0]) begin
                errors++;
                $display("FAIL %s o_aofs: got %h required %h", name, {o_aofs[0], o_aofs[1]}, exp_q[0]);
            end
            checks++;
            if (o_islast !== last_q[0]) begin
                errors++;
                $display("FAIL %s o_islast: got %b required %b", name, o_islast, last_q[0]);
            end
            checks++;
            if ({o_bofs[0], o_bofs[1]} !== {b0, b1}) begin
                errors++;
                $display("FAIL %s o_bofs: got %h required %h", name, {o_bofs[0], o_bofs[1]}, {b0, b1});
            end
            checks++;
            if (tokdone !== (ack && last_q[0])) begin
                errors++;
                $display("FAIL %s tokdone: got %b required %b", name, tokdone, ack && last_q[0]);
            end
            if (ack) begin
                void'(exp_q.pop_front());
                void'(last_q.pop_front());
                n_acked++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ofs_ack = 1'b0;
        checks++;
        if (n_acked != n_exp) begin
            errors++;
            $display("FAIL %s offset_count: got %0d required %0d", name, n_acked, n_exp);
        end
        #1;
        checks++;
        if (ofs_rdy !== 1'b0 || tokdone !== 1'b0) begin
            errors++;
            $display("FAIL %s after_tile: got ofs_rdy=%b tokdone=%b required 0/0", name, ofs_rdy, tokdone);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        abofs_rdy = 1'b1;
        d1_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (abofs_ack !== 1'b0 || ofs_rdy !== 1'b0 || tokdone !== 1'b0 || o_islast !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ack=%b rdy=%b done=%b last=%b required all 0",
                     abofs_ack, ofs_rdy, tokdone, o_islast);
        end
        checks++;
        if ({o_aofs[0], o_aofs[1], o_bofs[0], o_bofs[1]} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {o_aofs[0], o_aofs[1], o_bofs[0], o_bofs[1]});
        end
        checks++;
        if (d1_abofs_ack !== 1'b0 || d1_ofs_rdy !== 1'b0 || d1_o_aofs[0] !== '0) begin
            errors++;
            $display("FAIL reset_d1: got ack=%b rdy=%b aofs=%h required 0", d1_abofs_ack, d1_ofs_rdy, d1_o_aofs[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        abofs_rdy = 1'b0;
        d1_rdy = 1'b0;
        #1;
        checks++;
        if (dbg_state !== ACC_IDLE || ofs_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got state=%0d rdy=%b required IDLE/0", dbg_state, ofs_rdy);
        end
    endtask

    task automatic test_basic();
        run_tile(8'h11, 8'h22, 0, 0, 1, 2, 0, "basic");
    endtask

    task automatic test_backpressure();
        run_tile(8'h33, 8'h44, 0, 0, 1, 2, 1, "backpressure");
    endtask

    task automatic test_degenerate();
        run_tile(8'h55, 8'h66, 3, 5, 3, 2, 0, "degenerate");
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            run_tile(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                     W'($urandom_range(0, 5)), W'($urandom_range(0, 5)),
                     W'($urandom_range(0, 5)), W'($urandom_range(0, 5)), 2, "random");
        end
    endtask

    // Tile A = {0,0}..{0,1} (2 offsets), tile B = {2,2} (1 offset) offered during A.
    task automatic test_back_to_back();
        bit b_taken;
        int n;
        @(posedge clk); #1;
        abofs_rdy = 1'b1;
        bofs = '{8'h0a, 8'h0a}; aofs = '{0, 0}; alast = '{0, 1};
        #1;
        checks++;
        if (abofs_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b ack_a: got %b required 1", abofs_ack);
        end
        @(posedge clk); #1;
        bofs = '{8'h0b, 8'h0b}; aofs = '{2, 2}; alast = '{2, 2};
        ofs_ack = 1'b1;
        #1;
        b_taken = abofs_ack;
        checks++;
        if (abofs_ack !== PF) begin
            errors++;
            $display("FAIL b2b early_ack_b: got %b required %b", abofs_ack, PF);
        end
        checks++;
        if (ofs_rdy !== 1'b1 || {o_aofs[0], o_aofs[1]} !== 16'h0000 || o_islast !== 1'b0) begin
            errors++;
            $display("FAIL b2b a0: got rdy=%b aofs=%h last=%b required 1/0000/0",
                     ofs_rdy, {o_aofs[0], o_aofs[1]}, o_islast);
        end
        @(posedge clk); #1;
        abofs_rdy = !b_taken;
        #1;
        if (abofs_rdy && abofs_ack) b_taken = 1'b1;
        checks++;
        if ({o_aofs[0], o_aofs[1]} !== 16'h0001 || o_islast !== 1'b1 || tokdone !== 1'b1) begin
            errors++;
            $display("FAIL b2b a1: got aofs=%h last=%b done=%b required 0001/1/1",
                     {o_aofs[0], o_aofs[1]}, o_islast, tokdone);
        end
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            abofs_rdy = !b_taken;
            ofs_ack = ofs_rdy;
            #1;
            if (abofs_rdy && abofs_ack) b_taken = 1'b1;
            n++;
            if (ofs_rdy) break;
        end
        checks++;
        if (n != (PF ? 1 : 2)) begin
            errors++;
            $display("FAIL b2b gap: got %0d cycles required %0d", n, PF ? 1 : 2);
        end
        checks++;
        if (ofs_rdy !== 1'b1 || {o_aofs[0], o_aofs[1]} !== 16'h0202 || o_islast !== 1'b1 ||
            tokdone !== 1'b1 || {o_bofs[0], o_bofs[1]} !== 16'h0b0b) begin
            errors++;
            $display("FAIL b2b tile_b: got rdy=%b aofs=%h last=%b done=%b bofs=%h required 1/0202/1/1/0b0b",
                     ofs_rdy, {o_aofs[0], o_aofs[1]}, o_islast, tokdone, {o_bofs[0], o_bofs[1]});
        end
        @(posedge clk); #1;
        ofs_ack = 1'b0;
        abofs_rdy = 1'b0;
        #1;
        checks++;
        if (ofs_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b end: got ofs_rdy=%b required 0", ofs_rdy);
        end
    endtask

    // Reset after two of six offsets, then a fresh token must start from its own aofs.
    task automatic test_mid_reset();
        @(posedge clk); #1;
        abofs_rdy = 1'b1;
        bofs = '{8'h99, 8'h99}; aofs = '{0, 0}; alast = '{1, 2};
        #1;
        checks++;
        if (abofs_ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset ack: got %b required 1", abofs_ack);
        end
        @(posedge clk); #1;
        abofs_rdy = 1'b0;
        ofs_ack = 1'b1;
        #1;
        checks++;
        if ({o_aofs[0], o_aofs[1]} !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset first: got %h required 0000", {o_aofs[0], o_aofs[1]});
        end
        @(posedge clk); #2;
        checks++;
        if ({o_aofs[0], o_aofs[1]} !== 16'h0001 || tokdone !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset second: got %h done=%b required 0001/0", {o_aofs[0], o_aofs[1]}, tokdone);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ofs_ack = 1'b0;
        abofs_rdy = 1'b1;
        #1;
        checks++;
        if (ofs_rdy !== 1'b0 || abofs_ack !== 1'b0 || tokdone !== 1'b0 || o_islast !== 1'b0 ||
            {o_aofs[0], o_aofs[1], o_bofs[0], o_bofs[1]} !== '0) begin
            errors++;
            $display("FAIL mid_reset during: got rdy=%b ack=%b done=%b last=%b data=%h required all 0",
                     ofs_rdy, abofs_ack, tokdone, o_islast, {o_aofs[0], o_aofs[1], o_bofs[0], o_bofs[1]});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        abofs_rdy = 1'b0;
        #1;
        checks++;
        if (ofs_rdy !== 1'b0 || tokdone !== 1'b0 || dbg_state !== ACC_IDLE) begin
            errors++;
            $display("FAIL mid_reset after: got rdy=%b done=%b state=%0d required 0/0/IDLE",
                     ofs_rdy, tokdone, dbg_state);
        end
        run_tile(8'h77, 8'h78, 1, 0, 2, 1, 0, "mid_reset_next");
    endtask

    // DIM=1 with the top two values of the word: no wrap past max.
    task automatic test_large();
        @(posedge clk); #1;
        d1_rdy = 1'b1;
        d1_bofs[0] = 8'h5a; d1_aofs[0] = 8'hfe; d1_alast[0] = 8'hff;
        #1;
        checks++;
        if (d1_abofs_ack !== 1'b1) begin
            errors++;
            $display("FAIL large ack: got %b required 1", d1_abofs_ack);
        end
        @(posedge clk); #1;
        d1_rdy = 1'b0;
        d1_ofs_ack = 1'b1;
        #1;
        checks++;
        if (d1_ofs_rdy !== 1'b1 || d1_o_aofs[0] !== 8'hfe || d1_o_islast !== 1'b0 || d1_tokdone !== 1'b0) begin
            errors++;
            $display("FAIL large first: got rdy=%b aofs=%h last=%b done=%b required 1/fe/0/0",
                     d1_ofs_rdy, d1_o_aofs[0], d1_o_islast, d1_tokdone);
        end
        @(posedge clk); #2;
        checks++;
        if (d1_ofs_rdy !== 1'b1 || d1_o_aofs[0] !== 8'hff || d1_o_islast !== 1'b1 ||
            d1_tokdone !== 1'b1 || d1_o_bofs[0] !== 8'h5a) begin
            errors++;
            $display("FAIL large second: got rdy=%b aofs=%h last=%b done=%b bofs=%h required 1/ff/1/1/5a",
                     d1_ofs_rdy, d1_o_aofs[0], d1_o_islast, d1_tokdone, d1_o_bofs[0]);
        end
        @(posedge clk); #1;
        d1_ofs_ack = 1'b0;
        #1;
        checks++;
        if (d1_ofs_rdy !== 1'b0) begin
            errors++;
            $display("FAIL large end: got ofs_rdy=%b required 0", d1_ofs_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_degenerate();
        test_back_to_back();
        test_mid_reset();
        test_large();
        test_random();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
